ex_stage: RTL and testbench

Execute stage sitting directly downstream of the ID/EX pipeline register and driving the EX/MEM boundary. Combines operand forwarding, a single-cycle ALU, an iterative 32-cycle multiplier, and the EX/MEM output register. While a multiply is in progress it asserts `busy_o` so upstream stages hold. It honours the data-cache stall `MemStall_i` by freezing its output register.

---
 rtl/ex_stage.sv | 154 +++++++++++++++
 tb/tb_ex_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-iteration shift-add
// multiplier and the EX/MEM output register, with bubble/stall handling.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  RS1_i,
  input  logic [4:0]  RS2_i,
  input  logic [4:0]  RD_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic        ALUSrc_i,
  input  logic        MemtoReg_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  WB_RD_i,
  input  logic        WB_RegWrite_i,
  input  logic [31:0] WB_data_i,
  input  logic        MemStall_i,
  output logic [31:0] ALUres_o,
  output logic [31:0] RS2data_o,
  output logic [4:0]  RD_o,
  output logic        MemtoReg_o,
  output logic        MemWrite_o,
  output logic        MemRead_o,
  output logic        RegWrite_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  typedef struct packed {
    logic [31:0] alures;
    logic [31:0] rs2data;
    logic [4:0]  rd;
    logic        memtoreg;
    logic        memwrite;
    logic        memread;
    logic        regwrite;
  } exmem_t;

  state_e      state_q, state_d;
  exmem_t      exmem_q, exmem_d;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] fwd_a, fwd_b, op_b, alu_res;
  logic        mul_start;

  assign ALUres_o   = exmem_q.alures;
  assign RS2data_o  = exmem_q.rs2data;
  assign RD_o       = exmem_q.rd;
  assign MemtoReg_o = exmem_q.memtoreg;
  assign MemWrite_o = exmem_q.memwrite;
  assign MemRead_o  = exmem_q.memread;
  assign RegWrite_o = exmem_q.regwrite;

  // EX/MEM source has priority over MEM/WB; x0 is never forwarded.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rdata,
                                      input exmem_t em, input logic wb_we,
                                      input logic [4:0] wb_rd, input logic [31:0] wb_data);
    if (em.regwrite && em.rd != 5'd0 && em.rd == rs)      return em.alures;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == rs)       return wb_data;
    else                                                  return rdata;
  endfunction

  assign fwd_a = fwd(RS1_i, RS1data_i, exmem_q, WB_RegWrite_i, WB_RD_i, WB_data_i);
  assign fwd_b = fwd(RS2_i, RS2data_i, exmem_q, WB_RegWrite_i, WB_RD_i, WB_data_i);
  assign op_b  = ALUSrc_i ? imm_i : fwd_b;

  // MUL encoding yields 0 here; products only come from the iterative unit.
  always_comb begin
    alu_res = 32'd0;
    case (ALUCtrl_i)
      3'b000:  alu_res = fwd_a & op_b;
      3'b001:  alu_res = fwd_a ^ op_b;
      3'b010:  alu_res = fwd_a << op_b[4:0];
      3'b011:  alu_res = fwd_a + op_b;
      3'b100:  alu_res = fwd_a - op_b;
      3'b110:  alu_res = 32'($signed(fwd_a) >>> op_b[4:0]);
      default: alu_res = 32'd0;
    endcase
  end

  assign mul_start = (state_q == S_IDLE) && (ALUCtrl_i == 3'b101) && RegWrite_i && !MemStall_i;
  assign busy_o    = (state_q == S_MUL) || mul_start;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: if (mul_start) begin
        mcand_d  = fwd_a;
        mplier_d = op_b;
        acc_d    = 32'd0;
        cnt_d    = 5'd0;
        state_d  = S_MUL;
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE:  if (!MemStall_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall freezes everything; otherwise DONE commits the product, busy inserts a bubble.
  always_comb begin
    exmem_d = exmem_q;
    if (!MemStall_i) begin
      if (state_q == S_DONE || !busy_o) begin
        exmem_d.alures   = (state_q == S_DONE) ? acc_q : alu_res;
        exmem_d.rs2data  = fwd_b;
        exmem_d.rd       = RD_i;
        exmem_d.memtoreg = MemtoReg_i;
        exmem_d.memwrite = MemWrite_i;
        exmem_d.memread  = MemRead_i;
        exmem_d.regwrite = RegWrite_i;
      end else begin
        exmem_d.memtoreg = 1'b0;
        exmem_d.memwrite = 1'b0;
        exmem_d.memread  = 1'b0;
        exmem_d.regwrite = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      exmem_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      exmem_q  <= exmem_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, multiplier timing, stall and reset abort.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] RS1data_i, RS2data_i, imm_i, WB_data_i;
  logic [4:0]  RS1_i, RS2_i, RD_i, WB_RD_i;
  logic [2:0]  ALUCtrl_i;
  logic        ALUSrc_i, MemtoReg_i, MemWrite_i, MemRead_i, RegWrite_i;
  logic        WB_RegWrite_i, MemStall_i;
  logic [31:0] ALUres_o, RS2data_o;
  logic [4:0]  RD_o;
  logic        MemtoReg_o, MemWrite_o, MemRead_o, RegWrite_o, busy_o;
  int          n_cmp = 0, n_bad = 0;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i),
    .RS1_i(RS1_i), .RS2_i(RS2_i), .RD_i(RD_i), .ALUCtrl_i(ALUCtrl_i), .ALUSrc_i(ALUSrc_i),
    .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .RegWrite_i(RegWrite_i),
    .WB_RD_i(WB_RD_i), .WB_RegWrite_i(WB_RegWrite_i), .WB_data_i(WB_data_i), .MemStall_i(MemStall_i),
    .ALUres_o(ALUres_o), .RS2data_o(RS2data_o), .RD_o(RD_o),
    .MemtoReg_o(MemtoReg_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .RegWrite_o(RegWrite_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctl = {MemtoReg, MemWrite, MemRead, RegWrite}
  task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] im, input logic src, input logic [3:0] ctl);
    ALUCtrl_i = op; RS1_i = rs1; RS2_i = rs2; RD_i = rd;
    RS1data_i = d1; RS2data_i = d2; imm_i = im; ALUSrc_i = src;
    {MemtoReg_i, MemWrite_i, MemRead_i, RegWrite_i} = ctl;
  endtask

  function automatic logic [3:0] ctl_o();
    return {MemtoReg_o, MemWrite_o, MemRead_o, RegWrite_o};
  endfunction

  initial begin
    int n;
    int bubble_err;
    rst_i = 1'b1; MemStall_i = 1'b0;
    WB_RD_i = 5'd0; WB_RegWrite_i = 1'b0; WB_data_i = 32'd0;
    issue(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000);
    step(); step();
    rst_i = 1'b0;
    chk("rst_alures", ALUres_o, 32'd0);
    chk("rst_ctl", {28'd0, ctl_o()}, 32'd0);
    chk("rst_rd_rs2", {RD_o, RS2data_o[26:0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);

    issue(3'b011, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0001); step();
    chk("add", ALUres_o, 32'd12);
    chk("add_rd_ctl", {RD_o, ctl_o()}, {5'd3, 4'b0001});
    issue(3'b100, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 32'd0, 1'b0, 4'b0001); step();
    chk("sub_fwd_exmem", ALUres_o, 32'd7);
    WB_RD_i = 5'd3; WB_RegWrite_i = 1'b1; WB_data_i = 32'd12;
    issue(3'b011, 5'd3, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001); step();
    chk("add_fwd_wb", ALUres_o, 32'd12);
    WB_RD_i = 5'd5; WB_data_i = 32'd100;
    issue(3'b011, 5'd5, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001); step();
    chk("fwd_priority", ALUres_o, 32'd12);
    WB_RegWrite_i = 1'b0;
    issue(3'b011, 5'd6, 5'd6, 5'd7, 32'd0, 32'd0, 32'd10, 1'b1, 4'b0001); step();
    chk("addi_fwd", ALUres_o, 32'd22);
    chk("rs2_fwd_store", RS2data_o, 32'd12);
    issue(3'b011, 5'd1, 5'd2, 5'd0, 32'd99, 32'd0, 32'd0, 1'b0, 4'b0001); step();
    chk("rd0_prod", ALUres_o, 32'd99);
    WB_RD_i = 5'd0; WB_RegWrite_i = 1'b1; WB_data_i = 32'd55;
    issue(3'b011, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001); step();
    chk("x0_no_fwd", ALUres_o, 32'd0);
    WB_RegWrite_i = 1'b0;
    issue(3'b100, 5'd10, 5'd11, 5'd9, 32'd0, 32'd1, 32'd0, 1'b0, 4'b0001); step();
    chk("sub_wrap", ALUres_o, 32'hFFFF_FFFF);
    issue(3'b110, 5'd13, 5'd0, 5'd12, 32'h8000_0000, 32'd0, 32'd31, 1'b1, 4'b0001); step();
    chk("sra31", ALUres_o, 32'hFFFF_FFFF);
    issue(3'b010, 5'd15, 5'd0, 5'd14, 32'd1, 32'd0, 32'h21, 1'b1, 4'b0100); step();
    chk("sll_b21", ALUres_o, 32'd2);
    chk("sll_ctl", {28'd0, ctl_o()}, {28'd0, 4'b0100});
    issue(3'b000, 5'd17, 5'd18, 5'd16, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 4'b1011); step();
    chk("and", ALUres_o, 32'h0000_F000);
    chk("and_ctl", {28'd0, ctl_o()}, {28'd0, 4'b1011});
    issue(3'b001, 5'd20, 5'd21, 5'd19, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 4'b0001); step();
    chk("xor", ALUres_o, 32'h0000_0FF0);
    issue(3'b111, 5'd23, 5'd24, 5'd22, 32'd5, 32'd6, 32'd0, 1'b0, 4'b0001); step();
    chk("reserved", ALUres_o, 32'd0);

    // MUL 0xFFFFFFFF x 3: 33 busy cycles with bubbles, then commit.
    issue(3'b101, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 4'b0001); #1;
    chk("mul_busy_c0", {31'd0, busy_o}, 32'd1);
    n = 0; bubble_err = 0;
    while (busy_o && n < 50) begin
      n++; step();
      if (ctl_o() != 4'b0000) bubble_err++;
    end
    chk("mul_busy_len", n, 33);
    chk("mul_bubbles", bubble_err, 0);
    step();
    chk("mul_res", ALUres_o, 32'hFFFF_FFFD);
    chk("mul_rd_ctl", {RD_o, ctl_o()}, {5'd9, 4'b0001});

    // MUL 6x7 held in DONE by a 5-cycle stall.
    issue(3'b101, 5'd3, 5'd4, 5'd10, 32'd6, 32'd7, 32'd0, 1'b0, 4'b0001);
    n = 0;
    #1;
    while (busy_o && n < 50) begin n++; step(); end
    chk("mul2_busy_len", n, 33);
    MemStall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_res", ALUres_o, 32'hFFFF_FFFD);
      chk("stall_ctl", {28'd0, ctl_o(), busy_o}, 32'd0);
    end
    MemStall_i = 1'b0; step();
    chk("stall_release_res", ALUres_o, 32'd42);
    chk("stall_release_rd", {RD_o, ctl_o()}, {5'd10, 4'b0001});

    // Reset abort at iteration 10, then re-run.
    issue(3'b101, 5'd3, 5'd4, 5'd11, 32'd6, 32'd7, 32'd0, 1'b0, 4'b0001);
    for (int i = 0; i < 10; i++) step();
    rst_i = 1'b1; step(); rst_i = 1'b0; #1;
    chk("abort_res", ALUres_o, 32'd0);
    chk("abort_rd_ctl_rs2", {RS2data_o[22:0], RD_o, ctl_o()}, 32'd0);
    chk("abort_busy_mul", {31'd0, busy_o}, 32'd1);
    ALUCtrl_i = 3'b011; #1;
    chk("abort_busy_add", {31'd0, busy_o}, 32'd0);
    ALUCtrl_i = 3'b101; #1;
    n = 0;
    do begin step(); n++; end while (!RegWrite_o && n < 60);
    chk("rerun_edges", n, 34);
    chk("rerun_res", ALUres_o, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
